// File: rtl/lsu_ctrl_pkg.sv
// Shared constants and types for the load/store unit.
package lsu_ctrl_pkg;

  localparam int unsigned ALEN = 32;
  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_HALF = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD2_WAIT, WR2} lsu_state_t;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return f3 inside {F3_BYTE, F3_HALF, F3_WORD};
    return f3 inside {F3_BYTE, F3_HALF, F3_WORD, F3_LBU, F3_LHU};
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load result alignment: shifts a two-word window right by the byte offset and
// sign/zero-extends the selected lane according to funct3.
module lsu_load_align
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = XLEN
) (
  input  logic [2*DATA_W-1:0] word_i,
  input  logic [1:0]          offset_i,
  input  logic [2:0]          funct3_i,
  output logic [DATA_W-1:0]   result_o
);

  logic [2*DATA_W-1:0] shifted;
  logic [DATA_W-1:0]   lane;
  logic                unused_shift;

  assign shifted      = word_i >> {offset_i, 3'b000};
  assign lane         = shifted[DATA_W-1:0];
  assign unused_shift = ^shifted[2*DATA_W-1:DATA_W];

  always_comb begin
    case (funct3_i)
      F3_BYTE: result_o = {{(DATA_W-8){lane[7]}}, lane[7:0]};
      F3_HALF: result_o = {{(DATA_W-16){lane[15]}}, lane[15:0]};
      F3_LBU:  result_o = {{(DATA_W-8){1'b0}}, lane[7:0]};
      F3_LHU:  result_o = {{(DATA_W-16){1'b0}}, lane[15:0]};
      default: result_o = lane;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit in front of DataMemory: byte enables, lane alignment, load sequencing and
// fault detection. Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into two words.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ALEN,
  parameter int unsigned DATA_W = XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  lsu_state_t state_q, state_d;

  logic [1:0]          off;
  logic                legal, misal, acc;
  logic [7:0]          be_base, be_full;
  logic [2*DATA_W-1:0] wdata_full;

  logic [1:0]          off_q;
  logic [2:0]          f3_q;
  logic [ADDR_W-3:0]   word_q;
  logic                split_q;
  logic [3:0]          be_hi_q;
  logic [DATA_W-1:0]   wdata_hi_q;
  logic [DATA_W-1:0]   lo_q;

  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                fault_q, fault_d;
  logic [ADDR_W-1:0]   fault_addr_q, fault_addr_d;

  logic                ctx_load;
  logic                mem_we_c;
  logic [3:0]          mem_be_c;
  logic [DATA_W-1:0]   load_result;

  assign off       = req_addr[1:0];
  assign req_ready = (state_q == IDLE);
  assign acc       = req_valid && req_ready;
  assign legal     = f3_legal(req_we, req_funct3);
  assign misal     = ((req_funct3[1:0] == 2'b01) && off[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (off != 2'b00));

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   be_base = 8'h01;
      2'b01:   be_base = 8'h03;
      default: be_base = 8'h0F;
    endcase
  end

  // Upper halves feed the second write of a split store.
  assign be_full    = be_base << off;
  assign wdata_full = {{DATA_W{1'b0}}, req_wdata} << {off, 3'b000};

  lsu_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .word_i   ({mem_rdata, (split_q ? lo_q : mem_rdata)}),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .result_o (load_result)
  );

  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr_q;
    ctx_load     = 1'b0;
    mem_we_c     = 1'b0;
    mem_be_c     = 4'b0000;
    mem_addr     = {word_q, 2'b00};
    mem_wdata    = '0;
    case (state_q)
      IDLE: begin
        mem_addr  = {req_addr[ADDR_W-1:2], 2'b00};
        mem_wdata = wdata_full[DATA_W-1:0];
        if (acc) begin
          ctx_load = 1'b1;
          if (!legal || (misal && !SplitEn)) begin
            fault_d      = 1'b1;
            fault_addr_d = req_addr;
          end else if (req_we) begin
            mem_we_c = 1'b1;
            mem_be_c = be_full[3:0];
            if (misal) state_d = WR2;
          end else begin
            state_d = misal ? RD2_WAIT : RD_WAIT;
          end
        end
      end
      RD2_WAIT: begin
        mem_addr = {word_q + 1'b1, 2'b00};
        state_d  = RD_WAIT;
      end
      RD_WAIT: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = load_result;
        state_d      = IDLE;
      end
      WR2: begin
        mem_we_c  = 1'b1;
        mem_be_c  = be_hi_q;
        mem_addr  = {word_q + 1'b1, 2'b00};
        mem_wdata = wdata_hi_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory port stays quiet while reset is held, even though IDLE is combinational.
  assign mem_we     = mem_we_c & ~rst;
  assign mem_be     = rst ? 4'b0000 : mem_be_c;
  assign mem_funct3 = F3_WORD;

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q      <= 2'b00;
      f3_q       <= F3_WORD;
      word_q     <= '0;
      split_q    <= 1'b0;
      be_hi_q    <= 4'b0000;
      wdata_hi_q <= '0;
      lo_q       <= '0;
    end else begin
      if (ctx_load) begin
        off_q      <= off;
        f3_q       <= req_funct3;
        word_q     <= req_addr[ADDR_W-1:2];
        split_q    <= misal;
        be_hi_q    <= be_full[7:4];
        wdata_hi_q <= wdata_full[2*DATA_W-1:DATA_W];
      end
      if (state_q == RD2_WAIT) lo_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with a byte-enabled synchronous-read memory model.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        fault;
  logic [31:0] fault_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .fault      (fault),
    .fault_addr (fault_addr),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_funct3 (mem_funct3),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMemory model: byte-enabled write, read data registered one cycle after the address.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    mem_rdata <= mem[mem_addr[9:2]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, output logic [31:0] data,
                         output int lat, output int pulses, output int faults);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = f3; req_addr = addr; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    data = '0; lat = -1; pulses = 0; faults = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i > 1) begin
        @(posedge clk); #1;
      end
      if (resp_valid === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat  = i;
          data = resp_rdata;
        end
      end
      if (fault === 1'b1) faults++;
    end
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;
    #3;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    n_tests++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
    n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b want 0", fault); end
    n_tests++; if (fault_addr !== 32'h0) begin n_fail++; $display("FAIL rst_fault_addr: got %h want 0", fault_addr); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    n_tests++; if (mem_be !== 4'b0) begin n_fail++; $display("FAIL rst_mem_be: got %b want 0000", mem_be); end
    n_tests++; if (mem_funct3 !== 3'b010) begin n_fail++; $display("FAIL mem_funct3: got %b want 010", mem_funct3); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_word();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'h12345678;
    #1;
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL sw_we: got %b want 1", mem_we); end
    n_tests++; if (mem_be !== 4'b1111) begin n_fail++; $display("FAIL sw_be: got %b want 1111", mem_be); end
    n_tests++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL sw_addr: got %h want 00000100", mem_addr); end
    n_tests++; if (mem_wdata !== 32'h12345678) begin n_fail++; $display("FAIL sw_wdata: got %h want 12345678", mem_wdata); end
    @(posedge clk); #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL sw_ready_after: got %b want 1", req_ready); end
  endtask

  // Issued immediately after test_store_word with no idle cycle in between.
  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h101; req_wdata = 32'h000000AA;
    #1;
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL sb_we: got %b want 1", mem_we); end
    n_tests++; if (mem_be !== 4'b0010) begin n_fail++; $display("FAIL sb_be: got %b want 0010", mem_be); end
    n_tests++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL sb_addr: got %h want 00000100", mem_addr); end
    n_tests++; if (mem_wdata !== 32'h0000AA00) begin n_fail++; $display("FAIL sb_wdata: got %h want 0000aa00", mem_wdata); end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_load_word();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = '0;
    #1;
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL lw_we: got %b want 0", mem_we); end
    n_tests++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL lw_addr: got %h want 00000100", mem_addr); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL lw_ready_wait: got %b want 0", req_ready); end
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL lw_early_resp: got %b want 0", resp_valid); end
    @(posedge clk); #1;
    n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL lw_resp_valid: got %b want 1", resp_valid); end
    n_tests++; if (resp_rdata !== 32'h1234AA78) begin n_fail++; $display("FAIL lw_rdata: got %h want 1234aa78", resp_rdata); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL lw_ready_back: got %b want 1", req_ready); end
    @(posedge clk); #1;
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL lw_pulse_end: got %b want 0", resp_valid); end
    n_tests++; if (resp_rdata !== 32'h1234AA78) begin n_fail++; $display("FAIL lw_rdata_hold: got %h want 1234aa78", resp_rdata); end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3v  [8] = '{3'b000, 3'b100, 3'b101, 3'b000, 3'b001, 3'b001, 3'b101, 3'b010};
    logic [31:0] addv [8] = '{32'h101, 32'h101, 32'h102, 32'h100, 32'h100, 32'h102, 32'h102, 32'h100};
    logic [31:0] expv [8] = '{32'hFFFFFFAA, 32'h000000AA, 32'h00001234, 32'h00000078,
                              32'hFFFFAA78, 32'hFFFF8000, 32'h00008000, 32'h8000AA78};
    logic [31:0] d;
    int lat, pulses, faults;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) do_store(3'b001, 32'h102, 32'hFFFF8000);
      do_load(f3v[i], addv[i], d, lat, pulses, faults);
      n_tests++;
      if (d !== expv[i] || lat != 2 || pulses != 1 || faults != 0) begin
        n_fail++;
        $display("FAIL load_ext[%0d]: got data %h lat %0d pulses %0d faults %0d want data %h lat 2 pulses 1 faults 0",
                 i, d, lat, pulses, faults, expv[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] d;
    int lat, pulses, faults;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h102; req_wdata = 32'hCAFEF00D;
    #1;
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL mis_sw_we: got %b want 0", mem_we); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_tests++; if (fault !== 1'b1) begin n_fail++; $display("FAIL mis_sw_fault: got %b want 1", fault); end
    n_tests++; if (fault_addr !== 32'h102) begin n_fail++; $display("FAIL mis_sw_faddr: got %h want 00000102", fault_addr); end
    @(posedge clk); #1;
    n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL mis_fault_pulse: got %b want 0", fault); end
    n_tests++; if (fault_addr !== 32'h102) begin n_fail++; $display("FAIL mis_faddr_hold: got %h want 00000102", fault_addr); end
    do_load(3'b010, 32'h102, d, lat, pulses, faults);
    n_tests++;
    if (pulses != 0 || faults != 1 || fault_addr !== 32'h102) begin
      n_fail++;
      $display("FAIL mis_lw: got pulses %0d faults %0d faddr %h want pulses 0 faults 1 faddr 00000102",
               pulses, faults, fault_addr);
    end
    do_load(3'b001, 32'h101, d, lat, pulses, faults);
    n_tests++;
    if (pulses != 0 || faults != 1 || fault_addr !== 32'h101) begin
      n_fail++;
      $display("FAIL mis_lh: got pulses %0d faults %0d faddr %h want pulses 0 faults 1 faddr 00000101",
               pulses, faults, fault_addr);
    end
    do_load(3'b010, 32'h100, d, lat, pulses, faults);
    n_tests++; if (d !== 32'h8000AA78) begin n_fail++; $display("FAIL mis_no_write: got %h want 8000aa78", d); end
  endtask

  task automatic test_illegal();
    logic [31:0] d;
    int lat, pulses, faults;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b011; req_addr = 32'h100; req_wdata = 32'h55555555;
    #1;
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL ill_we: got %b want 0", mem_we); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_tests++; if (fault !== 1'b1) begin n_fail++; $display("FAIL ill_fault: got %b want 1", fault); end
    n_tests++; if (fault_addr !== 32'h100) begin n_fail++; $display("FAIL ill_faddr: got %h want 00000100", fault_addr); end
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL ill_resp: got %b want 0", resp_valid); end
    do_load(3'b110, 32'h108, d, lat, pulses, faults);
    n_tests++;
    if (pulses != 0 || faults != 1 || fault_addr !== 32'h108) begin
      n_fail++;
      $display("FAIL ill_load: got pulses %0d faults %0d faddr %h want pulses 0 faults 1 faddr 00000108",
               pulses, faults, fault_addr);
    end
  endtask

`ifdef LSU_MISALIGN_SPLIT_EN
  task automatic test_split();
    logic [31:0] d;
    int lat, pulses, faults;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h103; req_wdata = 32'hDDCCBBAA;
    #1;
    n_tests++;
    if (mem_we !== 1'b1 || mem_be !== 4'b1000 || mem_addr !== 32'h100 || mem_wdata !== 32'hAA000000) begin
      n_fail++;
      $display("FAIL split_sw_lo: got we %b be %b addr %h wdata %h want 1 1000 00000100 aa000000",
               mem_we, mem_be, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_tests++;
    if (mem_we !== 1'b1 || mem_be !== 4'b0111 || mem_addr !== 32'h104 || mem_wdata !== 32'h00DDCCBB ||
        req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL split_sw_hi: got we %b be %b addr %h wdata %h ready %b want 1 0111 00000104 00ddccbb 0",
               mem_we, mem_be, mem_addr, mem_wdata, req_ready);
    end
    @(posedge clk); #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL split_sw_ready: got %b want 1", req_ready); end
    do_load(3'b010, 32'h103, d, lat, pulses, faults);
    n_tests++;
    if (d !== 32'hDDCCBBAA || lat != 3 || pulses != 1 || faults != 0) begin
      n_fail++;
      $display("FAIL split_lw: got data %h lat %0d pulses %0d faults %0d want ddccbbaa lat 3 pulses 1 faults 0",
               d, lat, pulses, faults);
    end
    do_load(3'b101, 32'h103, d, lat, pulses, faults);
    n_tests++;
    if (d !== 32'h0000BBAA || lat != 3) begin
      n_fail++;
      $display("FAIL split_lhu: got data %h lat %0d want 0000bbaa lat 3", d, lat);
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d;
    int lat, pulses, faults;
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", req_ready); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        @(negedge clk);
        rst = 1'b0;
      end
      @(posedge clk); #1;
      if (resp_valid === 1'b1) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rmid_resp: got %0d pulses want 0", seen); end
`ifdef LSU_MISALIGN_SPLIT_EN
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h103; req_wdata = 32'hDDCCBBAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rmid_wr2_we: got %b want 0", mem_we); end
    @(negedge clk);
    rst = 1'b0;
`endif
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'h0BADBEEF;
    #1;
    n_tests++; if (mem_we !== 1'b0 || mem_be !== 4'b0000) begin
      n_fail++; $display("FAIL rst_store_we: got we %b be %b want 0 0000", mem_we, mem_be);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_load(3'b010, 32'h100, d, lat, pulses, faults);
`ifdef LSU_MISALIGN_SPLIT_EN
    n_tests++; if (d !== 32'hAA00AA78 || lat != 2) begin
      n_fail++; $display("FAIL post_rst_lw: got data %h lat %0d want aa00aa78 lat 2", d, lat);
    end
`else
    n_tests++; if (d !== 32'h8000AA78 || lat != 2) begin
      n_fail++; $display("FAIL post_rst_lw: got data %h lat %0d want 8000aa78 lat 2", d, lat);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_back_to_back();
    test_load_word();
    test_load_extend();
`ifdef LSU_MISALIGN_SPLIT_EN
    test_split();
`else
    test_misaligned();
`endif
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit that sits directly upstream of DataMemory, between the EX/MEM pipeline register and the memory port.
- Decodes funct3 and address, generates byte enables, and lane-aligns store data.
- Sequences DataMemory's synchronous read and extracts and sign/zero-extends load results.
- Detects misaligned and illegal accesses; back-pressures the pipeline with req_ready.

Parameters:
ADDR_W, ALEN, address width (from riscv_pkg)
DATA_W, XLEN, data width; only 32 is supported

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  pipeline presents a memory op
req_ready  out  1  unit can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-justified
resp_valid  out  1  one-cycle pulse; load data valid
resp_rdata  out  DATA_W  extended load result
fault  out  1  one-cycle pulse; misaligned or illegal access
fault_addr  out  ADDR_W  offending address, held until the next fault
mem_we  out  1  to DataMemory MemWrite
mem_be  out  4  to DataMemory be
mem_funct3  out  3  to DataMemory funct3; constant F3_WORD
mem_addr  out  ADDR_W  word-aligned address; bits [1:0] always 0
mem_wdata  out  DATA_W  lane-shifted store data
mem_rdata  in  DATA_W  DataMemory ReadData, valid the cycle after the address is presented

Behaviour:
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, fault=0, fault_addr=0, mem_we=0, mem_be=0.
- Accept rule: a request is accepted when req_valid && req_ready.
- Memory-side outputs in IDLE are combinational from req_*. In other states they come from registered context.
- Legal funct3:
  - stores: 000 SB, 001 SH, 010 SW
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - any other funct3 gives fault next cycle, no memory access.
- Byte enables: SB = 0001<<a[1:0]; SH = 0011<<a[1:0]; SW = 1111.
- Store data: mem_wdata = req_wdata << (8*a[1:0]).
- Misaligned: halfword with a[0]=1, or word with a[1:0]!=0.
- Store (aligned): mem_we=1 in the accept cycle; the write commits at that edge. Stays in IDLE, so back-to-back stores run at one per cycle.
- Load (aligned):
  - Accept cycle N: mem_addr driven, mem_we=0.
  - Go to RD_WAIT; req_ready=0 in N+1.
  - In N+1: shift mem_rdata right by 8*a[1:0], extend per funct3, register the result.
  - resp_valid=1 in N+2; state back to IDLE at the end of N+1, so the next request can be accepted in N+2.
- resp_rdata holds its value after the pulse.
- Misaligned, no split (macro undefined): mem_we forced 0, no memory access, fault=1 in the next cycle, fault_addr=req_addr.
- States: IDLE, RD_WAIT, plus RD2_WAIT and WR2 (split only).
- Fault and resp_valid are never asserted in the same cycle.
- Reset mid-operation: return to IDLE immediately. A pending response or second split write is dropped; no mem_we after reset asserts.

Optional Feature:
Macro: LSU_MISALIGN_SPLIT_EN
- Defined: misaligned accesses are split into two word accesses, at W=a&~3 and W+4. W+4 wraps modulo 2^ADDR_W.
- Store, cycle N: write the low part to W (be masked to lanes >= a[1:0]).
- Store, cycle N+1 (state WR2, req_ready=0): write the high part to W+4, with be and data carried over from the shift.
- Load: read W in N, read W+4 in N+1 while capturing the first word. Second word captured in N+2; concatenated, shifted and extended; resp_valid in N+3.
- Undefined: misaligned accesses fault as above.
- Illegal funct3 faults in both builds.

Decomposition:
- riscv_pkg additions: F3_HALF=001, F3_LHU=101 (alongside F3_BYTE, F3_WORD, F3_LBU); typedef enum lsu_state_t {IDLE, RD_WAIT, RD2_WAIT, WR2}.
- One natural sub-module: lsu_load_align, a combinational shift plus sign/zero extend taking {word_hi, word_lo}, offset and funct3.

Test Plan:
- Aligned SW 0x100 <- 0x12345678 -> mem_we=1, be=1111, mem_addr=0x100 in one cycle; req_ready stays 1.
- SB 0x101 <- 0xAA -> be=0010, mem_wdata=0x0000AA00, mem_addr=0x100. Then LW 0x100 -> resp_valid 2 cycles after accept, resp_rdata=0x1234AA78.
- LB 0x101 -> 0xFFFFFFAA; LBU 0x101 -> 0x000000AA; LHU 0x102 -> 0x00001234; LH 0x102 with memory 0x8000xxxx -> 0xFFFF8000.
- LW 0x102, macro undefined -> fault=1 next cycle, fault_addr=0x102, no mem_we, no resp_valid.
- Macro defined: SW 0x103 <- 0xDDCCBBAA -> be=1000 at 0x100, then be=0111 at 0x104. LW 0x103 -> resp_valid at N+3, data 0xDDCCBBAA.
- rst asserted in RD_WAIT -> resp_valid never pulses, req_ready=1 while reset is asserted. funct3=011 -> fault pulse, no memory access.
